// File: rtl/camac_read_sequencer_if.sv
// Bundle between the ISA register decode / CAMAC crate and the read sequencer.
// master = stimulus side (ISA decode plus crate model), slave = the sequencer.
interface camac_read_sequencer_if;
   logic        start;
   logic [4:0]  station;
   logic [3:0]  subaddr;
   logic [2:0]  func;
   logic        cb_prr;
   logic [15:0] cb_data_in;
   logic [11:0] cb_addr;
   logic        cb_cycle_n;
   logic        q_r;
   logic        isa_chrdy;
   logic        busy;
   logic [15:0] rd_data;
   logic        done;
   logic        timeout_err;
   logic        overrun;

   modport master (
      output start, station, subaddr, func, cb_prr, cb_data_in,
      input  cb_addr, cb_cycle_n, q_r, isa_chrdy, busy, rd_data, done,
             timeout_err, overrun
   );

   modport slave (
      input  start, station, subaddr, func, cb_prr, cb_data_in,
      output cb_addr, cb_cycle_n, q_r, isa_chrdy, busy, rd_data, done,
             timeout_err, overrun
   );
endinterface

// File: rtl/camac_read_sequencer.sv
// One CAMAC dataway read cycle: address setup, strobe until the crate answers
// (or the timeout expires), latch the read word, address hold, done pulse.
// Every output is a flop so the crate-side strobe cannot glitch.
module camac_read_sequencer #(
   parameter int SETUP_CYCLES   = 2,
   parameter int STROBE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int HOLD_CYCLES    = 1
) (
   input  logic isa_clk,
   input  logic isa_reset,
   camac_read_sequencer_if.slave bus
);

   localparam int M1   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int M2   = (M1 > HOLD_CYCLES) ? M1 : HOLD_CYCLES;
   localparam int MAXP = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
   localparam int CW   = $clog2(MAXP);

   localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] STROBE_LAST  = CW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST    = CW'(HOLD_CYCLES - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_STROBE = 3'd2;
   localparam logic [2:0] S_LATCH  = 3'd3;
   localparam logic [2:0] S_ABORT  = 3'd4;
   localparam logic [2:0] S_HOLD   = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] ph_cnt_q, ph_cnt_d;   // setup / hold phase length
   logic [CW-1:0] st_cnt_q, st_cnt_d;   // strobe length and timeout
   logic          prr_m_q, prr_s_q;
   logic [11:0]   cb_addr_q;
   logic [15:0]   rd_data_q;
   logic          cb_cycle_n_q, q_r_q, chrdy_q, busy_q, done_q;
   logic          tmo_q, ovr_q;
   logic          accept;

   assign accept = bus.start && (state_q == S_IDLE);

   // Next-state and counter logic; LATCH is tested first so a response that
   // arrives on the last timeout count still completes the read.
   always_comb begin
      state_d  = state_q;
      ph_cnt_d = ph_cnt_q;
      st_cnt_d = st_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d  = S_SETUP;
               ph_cnt_d = '0;
            end
         end
         S_SETUP: begin
            if (ph_cnt_q == SETUP_LAST) begin
               state_d  = S_STROBE;
               ph_cnt_d = '0;
               st_cnt_d = '0;
            end else begin
               ph_cnt_d = ph_cnt_q + CW'(1);
            end
         end
         S_STROBE: begin
            if ((st_cnt_q >= STROBE_LAST) && !prr_s_q)
               state_d = S_LATCH;
            else if ((st_cnt_q == TIMEOUT_LAST) && prr_s_q)
               state_d = S_ABORT;
            else
               st_cnt_d = st_cnt_q + CW'(1);
         end
         S_LATCH, S_ABORT: begin
            state_d  = S_HOLD;
            ph_cnt_d = '0;
         end
         S_HOLD: begin
            if (ph_cnt_q == HOLD_LAST)
               state_d = S_DONE;
            else
               ph_cnt_d = ph_cnt_q + CW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State, synchronizer, datapath and registered outputs (decoded from state_d).
   always_ff @(posedge isa_clk) begin
      if (isa_reset) begin
         state_q      <= S_IDLE;
         ph_cnt_q     <= '0;
         st_cnt_q     <= '0;
         prr_m_q      <= 1'b1;
         prr_s_q      <= 1'b1;
         cb_addr_q    <= '0;
         rd_data_q    <= '0;
         cb_cycle_n_q <= 1'b1;
         q_r_q        <= 1'b1;
         chrdy_q      <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         tmo_q        <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ph_cnt_q     <= ph_cnt_d;
         st_cnt_q     <= st_cnt_d;
         prr_m_q      <= bus.cb_prr;
         prr_s_q      <= prr_m_q;
         cb_cycle_n_q <= !((state_d == S_STROBE) || (state_d == S_LATCH));
         q_r_q        <= (state_d == S_IDLE) || (state_d == S_DONE);
         chrdy_q      <= (state_d == S_IDLE) || (state_d == S_DONE);
         busy_q       <= (state_d != S_IDLE);
         done_q       <= (state_d == S_DONE);
         if (accept)
            cb_addr_q <= {bus.func, bus.subaddr, bus.station};
         if (state_q == S_LATCH)
            rd_data_q <= bus.cb_data_in;
         if (accept)
            tmo_q <= 1'b0;
         else if (state_q == S_ABORT)
            tmo_q <= 1'b1;
         if (bus.start && (state_q != S_IDLE))
            ovr_q <= 1'b1;
      end
   end

   assign bus.cb_addr     = cb_addr_q;
   assign bus.cb_cycle_n  = cb_cycle_n_q;
   assign bus.q_r         = q_r_q;
   assign bus.isa_chrdy   = chrdy_q;
   assign bus.busy        = busy_q;
   assign bus.rd_data     = rd_data_q;
   assign bus.done        = done_q;
   assign bus.timeout_err = tmo_q;
   assign bus.overrun     = ovr_q;

endmodule

// File: tb/tb_camac_read_sequencer.sv
// Directed bench for camac_read_sequencer with default parameters.
module tb_camac_read_sequencer;

   logic isa_clk = 1'b0;
   logic isa_reset;
   int   n_chk  = 0;
   int   n_fail = 0;

   int          done_at, ndone, strobe_lo, chrdy_lo, tmo1;
   logic [11:0] addr1;

   camac_read_sequencer_if bus ();

   camac_read_sequencer dut (
      .isa_clk   (isa_clk),
      .isa_reset (isa_reset),
      .bus       (bus)
   );

   always #5 isa_clk = ~isa_clk;

   task automatic tick;
      @(posedge isa_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One read cycle. prr_at: tick after which cb_prr goes low (0 = low from the
   // start, -1 = never). extra_at: tick after which a second start is pulsed.
   task automatic do_cycle(input logic [4:0] n, input logic [3:0] a, input logic [2:0] f,
                           input logic [15:0] d, input int prr_at, input int extra_at,
                           input int ticks, output int o_done_at, output int o_ndone,
                           output int o_strobe, output int o_chrdy,
                           output logic [11:0] o_addr, output int o_tmo1);
      bus.cb_prr     = (prr_at == 0) ? 1'b0 : 1'b1;
      bus.cb_data_in = d;
      bus.station    = n;
      bus.subaddr    = a;
      bus.func       = f;
      tick(); tick(); tick();
      o_done_at = -1; o_ndone = 0; o_strobe = 0; o_chrdy = 0; o_addr = '0; o_tmo1 = -1;
      bus.start = 1'b1;
      for (int k = 1; k <= ticks; k++) begin
         tick();
         if (bus.done) begin
            o_ndone++;
            if (o_done_at < 0) o_done_at = k;
         end
         if (!bus.cb_cycle_n) o_strobe++;
         if (!bus.isa_chrdy)  o_chrdy++;
         if (k == 1) begin
            o_addr = bus.cb_addr;
            o_tmo1 = int'(bus.timeout_err);
         end
         if (k == prr_at) bus.cb_prr = 1'b0;
         bus.start = (k == extra_at) ? 1'b1 : 1'b0;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      isa_reset      = 1'b1;
      bus.start      = 1'b0;
      bus.station    = '0;
      bus.subaddr    = '0;
      bus.func       = '0;
      bus.cb_prr     = 1'b1;
      bus.cb_data_in = '0;
      tick(); tick(); tick();

      chk("rst_cycle_n", bus.cb_cycle_n, 1);
      chk("rst_q_r", bus.q_r, 1);
      chk("rst_chrdy", bus.isa_chrdy, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_addr", bus.cb_addr, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_tmo_ovr", {bus.timeout_err, bus.overrun}, 0);
      isa_reset = 1'b0;

      // 1: crate responds immediately
      do_cycle(5'd6, 4'd2, 3'd0, 16'hA5C3, 0, -1, 12,
               done_at, ndone, strobe_lo, chrdy_lo, addr1, tmo1);
      chk("t1_addr", addr1, 12'h046);
      chk("t1_done_at", done_at, 9);
      chk("t1_ndone", ndone, 1);
      chk("t1_strobe", strobe_lo, 5);
      chk("t1_chrdy", chrdy_lo, 8);
      chk("t1_rd_data", bus.rd_data, 16'hA5C3);
      chk("t1_idle", {bus.busy, bus.q_r, bus.cb_cycle_n, bus.timeout_err}, 4'b0110);

      // 2: late response stretches the strobe by the synchronizer delay
      do_cycle(5'd17, 4'd9, 3'd2, 16'h1234, 20, -1, 30,
               done_at, ndone, strobe_lo, chrdy_lo, addr1, tmo1);
      chk("t2_addr", addr1, 12'h531);
      chk("t2_done_at", done_at, 25);
      chk("t2_strobe", strobe_lo, 21);
      chk("t2_tmo", bus.timeout_err, 0);
      chk("t2_rd_data", bus.rd_data, 16'h1234);

      // 3: no response -> timeout, rd_data untouched
      do_cycle(5'd3, 4'd1, 3'd1, 16'hFFFF, -1, -1, 75,
               done_at, ndone, strobe_lo, chrdy_lo, addr1, tmo1);
      chk("t3_done_at", done_at, 69);
      chk("t3_ndone", ndone, 1);
      chk("t3_strobe", strobe_lo, 64);
      chk("t3_tmo", bus.timeout_err, 1);
      chk("t3_rd_data", bus.rd_data, 16'h1234);

      // next good start clears the sticky timeout at acceptance
      do_cycle(5'd1, 4'd0, 3'd0, 16'h0F0F, 0, -1, 12,
               done_at, ndone, strobe_lo, chrdy_lo, addr1, tmo1);
      chk("t3b_tmo_at_accept", tmo1, 0);
      chk("t3b_done_at", done_at, 9);
      chk("t3b_rd_data", bus.rd_data, 16'h0F0F);

      // 6: response lands on the last timeout count -> LATCH wins
      do_cycle(5'd31, 4'd15, 3'd7, 16'h5A5A, 64, -1, 75,
               done_at, ndone, strobe_lo, chrdy_lo, addr1, tmo1);
      chk("t6_addr", addr1, 12'hFFF);
      chk("t6_done_at", done_at, 69);
      chk("t6_strobe", strobe_lo, 65);
      chk("t6_tmo", bus.timeout_err, 0);
      chk("t6_rd_data", bus.rd_data, 16'h5A5A);
      chk("t6_ovr_clear", bus.overrun, 0);

      // 4: second start while busy is ignored and flagged
      do_cycle(5'd6, 4'd2, 3'd0, 16'h7777, 0, 3, 20,
               done_at, ndone, strobe_lo, chrdy_lo, addr1, tmo1);
      chk("t4_ndone", ndone, 1);
      chk("t4_done_at", done_at, 9);
      chk("t4_overrun", bus.overrun, 1);
      do_cycle(5'd2, 4'd2, 3'd0, 16'h8888, 0, -1, 12,
               done_at, ndone, strobe_lo, chrdy_lo, addr1, tmo1);
      chk("t4_ovr_persist", bus.overrun, 1);
      chk("t4b_rd_data", bus.rd_data, 16'h8888);

      // 5: reset in STROBE aborts immediately with no done pulse
      bus.cb_prr = 1'b1;
      tick(); tick(); tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick(); tick(); tick();
      chk("t5_in_strobe", bus.cb_cycle_n, 0);
      isa_reset = 1'b1;
      tick();
      chk("t5_rst_outs", {bus.cb_cycle_n, bus.q_r, bus.isa_chrdy, bus.busy, bus.done}, 5'b11100);
      chk("t5_rst_ovr", bus.overrun, 0);
      isa_reset = 1'b0;
      ndone = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.done) ndone++;
      end
      chk("t5_no_done", ndone, 0);
      do_cycle(5'd9, 4'd4, 3'd0, 16'hC001, 0, -1, 12,
               done_at, ndone, strobe_lo, chrdy_lo, addr1, tmo1);
      chk("t5_fresh_addr", addr1, 12'h089);
      chk("t5_fresh_done", done_at, 9);
      chk("t5_fresh_data", bus.rd_data, 16'hC001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
